byte_lane_ram: RTL and testbench

BYTE_LANE_RAM -- requirements
Module: byte_lane_ram

---
 rtl/byte_lane_ram_if.sv | 26 ++
 rtl/byte_lane_ram.sv | 183 ++++++++++++++++++
 tb/tb_byte_lane_ram.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_lane_ram_if.sv
// Request/response bundle for byte_lane_ram: one access in flight, completion
// signalled by a single done pulse qualified by fault.
interface byte_lane_ram_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  sgn;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  busy;
  logic                  done;
  logic                  fault;

  modport master (
    output req, we, size, sgn, address, wdata,
    input  rdata, busy, done, fault
  );

  modport slave (
    input  req, we, size, sgn, address, wdata,
    output rdata, busy, done, fault
  );
endinterface

// File: rtl/byte_lane_ram.sv
// Byte-addressable little-endian RAM with a fixed wait latency per access.
// Storage is four byte lanes so any access stays inside one aligned word.
module byte_lane_ram #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 1
) (
  input logic            clk,
  input logic            rst_n,
  byte_lane_ram_if.slave bus
);

  localparam int unsigned WA    = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << WA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_sgn;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_fault;
  logic [7:0]            r_mem [4][DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_fault;
  logic [1:0]            w_off;
  logic [WA-1:0]         w_waddr;
  logic [31:0]           w_word;
  logic [31:0]           w_rot;
  logic [31:0]           w_load;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.fault   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        bus.fault   = r_fault;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fault = (r_size == 2'b11) || ((r_size == 2'b01) && r_addr[0]);
  assign w_off   = r_addr[1:0];
  assign w_waddr = r_addr[ADDR_WIDTH-1:2];
  assign w_word  = {r_mem[3][w_waddr], r_mem[2][w_waddr],
                    r_mem[1][w_waddr], r_mem[0][w_waddr]};

  // Rotating the aligned word puts the addressed byte in lane 0, which serves
  // byte, halfword and word loads with one mux.
  always_comb begin
    w_rot = w_word;
    case (w_off)
      2'd0: w_rot = w_word;
      2'd1: w_rot = {w_word[7:0],  w_word[31:8]};
      2'd2: w_rot = {w_word[15:0], w_word[31:16]};
      2'd3: w_rot = {w_word[23:0], w_word[31:24]};
      default: w_rot = w_word;
    endcase
  end

  always_comb begin
    w_load = '0;
    if (!w_fault) begin
      case (r_size)
        2'b00:   w_load = r_sgn ? {{24{w_rot[7]}}, w_rot[7:0]}
                                : {24'h0, w_rot[7:0]};
        2'b01:   w_load = r_sgn ? {{16{w_rot[15]}}, w_rot[15:0]}
                                : {16'h0, w_rot[15:0]};
        2'b10:   w_load = w_rot;
        default: w_load = '0;
      endcase
    end
  end

  always_comb begin
    w_be     = '0;
    w_wlanes = r_wdata;
    case (r_size)
      2'b00: begin
        w_be     = 4'b0001 << w_off;
        w_wlanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
      end
      default: begin
        w_be     = '0;
        w_wlanes = r_wdata;
      end
    endcase
    if (!(w_commit && r_we && !w_fault)) begin
      w_be = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_sgn   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY);
        r_we    <= bus.we;
        r_size  <= bus.size;
        r_sgn   <= bus.sgn;
        r_addr  <= bus.address;
        r_wdata <= bus.wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_fault <= w_fault;
        if (!r_we || w_fault) begin
          r_rdata <= w_load;
        end
      end
    end
  end

  // Contents survive reset; only committed, non-faulting stores write.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        r_mem[i][w_waddr] <= w_wlanes[8*i +: 8];
      end
    end
  end

  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_byte_lane_ram.sv
// Bench for byte_lane_ram: two instances (latency 1 and 4) checked every cycle
// against a byte-array reference model, plus literal scenario expectations.
module tb_byte_lane_ram;

  localparam int unsigned AW   = 8;
  localparam int unsigned NB   = 1 << AW;
  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_s   [2];
  logic          we_s    [2];
  logic [1:0]    size_s  [2];
  logic          sgn_s   [2];
  logic [AW-1:0] addr_s  [2];
  logic [31:0]   wdata_s [2];
  logic [31:0]   rdata_o [2];
  logic          busy_o  [2];
  logic          done_o  [2];
  logic          fault_o [2];

  byte_lane_ram_if #(.ADDR_WIDTH(AW)) if0 ();
  byte_lane_ram_if #(.ADDR_WIDTH(AW)) if1 ();

  assign if0.req = req_s[0];  assign if0.we = we_s[0];  assign if0.size = size_s[0];
  assign if0.sgn = sgn_s[0];  assign if0.address = addr_s[0];  assign if0.wdata = wdata_s[0];
  assign if1.req = req_s[1];  assign if1.we = we_s[1];  assign if1.size = size_s[1];
  assign if1.sgn = sgn_s[1];  assign if1.address = addr_s[1];  assign if1.wdata = wdata_s[1];
  assign rdata_o[0] = if0.rdata;  assign busy_o[0] = if0.busy;
  assign done_o[0]  = if0.done;   assign fault_o[0] = if0.fault;
  assign rdata_o[1] = if1.rdata;  assign busy_o[1] = if1.busy;
  assign done_o[1]  = if1.done;   assign fault_o[1] = if1.fault;

  byte_lane_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  byte_lane_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]    mdl_mem [2][NB];
  bit            m_act   [2];
  longint        m_acc   [2];
  bit            m_we    [2];
  logic [1:0]    m_sz    [2];
  bit            m_sg    [2];
  logic [AW-1:0] m_a     [2];
  logic [31:0]   m_wd    [2];
  bit            exp_busy  [2];
  bit            exp_done  [2];
  bit            exp_fault [2];
  logic [31:0]   exp_rdata [2] = '{32'h0, 32'h0};
  longint        edge_n = 0;

  function automatic longint lat_of(input int d);
    return (d == 0) ? longint'(LAT0) : longint'(LAT1);
  endfunction

  function automatic bit is_fault(input logic [1:0] sz, input logic [AW-1:0] a);
    return (sz == 2'b11) || ((sz == 2'b01) && a[0]);
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [1:0] sz,
                                             input bit sg, input logic [AW-1:0] a);
    int unsigned ai   = a;
    int unsigned base = ai & ~32'd3;
    int unsigned off  = ai & 32'd3;
    logic [31:0] v    = '0;
    if (is_fault(sz, a)) return '0;
    case (sz)
      2'b00: begin
        v = {24'h0, mdl_mem[d][ai]};
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = {16'h0, mdl_mem[d][ai + 1], mdl_mem[d][ai]};
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      default: begin
        for (int unsigned i = 0; i < 4; i++)
          v[8*i +: 8] = mdl_mem[d][base + ((off + i) % 4)];
      end
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d]     <= 1'b0;
        exp_busy[d]  <= 1'b0;
        exp_done[d]  <= 1'b0;
        exp_fault[d] <= 1'b0;
        exp_rdata[d] <= '0;
      end
    end else begin
      edge_n <= edge_n + 1;
      for (int d = 0; d < 2; d++) begin
        exp_done[d]  <= 1'b0;
        exp_fault[d] <= 1'b0;
        if (m_act[d]) begin
          if (edge_n == m_acc[d] + lat_of(d)) begin
            exp_done[d]  <= 1'b1;
            exp_fault[d] <= is_fault(m_sz[d], m_a[d]);
            if (is_fault(m_sz[d], m_a[d]) || !m_we[d]) begin
              exp_rdata[d] <= model_load(d, m_sz[d], m_sg[d], m_a[d]);
            end else begin
              case (m_sz[d])
                2'b00: mdl_mem[d][m_a[d]] <= m_wd[d][7:0];
                2'b01: begin
                  mdl_mem[d][m_a[d]]         <= m_wd[d][7:0];
                  mdl_mem[d][m_a[d] | 8'd1]  <= m_wd[d][15:8];
                end
                default: begin
                  for (int unsigned k = 0; k < 4; k++)
                    mdl_mem[d][(m_a[d] & 8'hFC) + AW'(k)] <= m_wd[d][8*k +: 8];
                end
              endcase
            end
          end
          if (edge_n == m_acc[d] + lat_of(d) + 1) begin
            m_act[d]    <= 1'b0;
            exp_busy[d] <= 1'b0;
          end
        end else if (req_s[d]) begin
          m_act[d]    <= 1'b1;
          exp_busy[d] <= 1'b1;
          m_acc[d]    <= edge_n;
          m_we[d]     <= we_s[d];
          m_sz[d]     <= size_s[d];
          m_sg[d]     <= sgn_s[d];
          m_a[d]      <= addr_s[d];
          m_wd[d]     <= wdata_s[d];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy%0d", d),  {31'h0, busy_o[d]},  {31'h0, exp_busy[d]});
      chk($sformatf("done%0d", d),  {31'h0, done_o[d]},  {31'h0, exp_done[d]});
      chk($sformatf("fault%0d", d), {31'h0, fault_o[d]}, {31'h0, exp_fault[d]});
      chk($sformatf("rdata%0d", d), rdata_o[d], exp_rdata[d]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input int d, input bit w, input logic [1:0] sz, input bit sg,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit flt, output int cyc);
    bit got = 0;
    rd = '0; flt = 1'b0; cyc = -1;
    req_s[d] = 1'b1; we_s[d] = w; size_s[d] = sz; sgn_s[d] = sg;
    addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk); #1;
    req_s[d]   = 1'b0;
    we_s[d]    = 1'($urandom);
    size_s[d]  = 2'($urandom);
    sgn_s[d]   = 1'($urandom);
    addr_s[d]  = AW'($urandom);
    wdata_s[d] = $urandom;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done_o[d]) begin
        got = 1; rd = rdata_o[d]; flt = fault_o[d]; cyc = i;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout%0d: done never seen, expected within 40 cycles", d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          flt;
    int          cyc;
    int          nbusy, ndone;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 0; we_s[d] = 0; size_s[d] = 0; sgn_s[d] = 0; addr_s[d] = 0; wdata_s[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", {31'h0, busy_o[d]}, 32'h0);
      chk("rst_done", {31'h0, done_o[d]}, 32'h0);
      chk("rst_rdata", rdata_o[d], 32'h0);
    end
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int unsigned wi = 0; wi < NB / 4; wi++)
        access(d, 1, 2'b10, 0, AW'(wi * 4), $urandom, rd, flt, cyc);

    access(0, 1, 2'b10, 0, 8'h10, 32'h1122_3344, rd, flt, cyc);
    chk("st_lat", 32'(cyc), 32'd1);
    chk("st_fault", {31'h0, flt}, 32'h0);
    access(0, 0, 2'b10, 0, 8'h10, 32'h0, rd, flt, cyc);
    chk("ldw10", rd, 32'h1122_3344);
    chk("ldw10_lat", 32'(cyc), 32'd1);
    access(0, 0, 2'b10, 1, 8'h11, 32'h0, rd, flt, cyc);
    chk("ldw11_rot", rd, 32'h4411_2233);
    access(0, 0, 2'b00, 0, 8'h13, 32'h0, rd, flt, cyc);
    chk("ldb13", rd, 32'h0000_0011);
    access(0, 1, 2'b00, 1, 8'h12, 32'hFFFF_FFAA, rd, flt, cyc);
    access(0, 0, 2'b10, 0, 8'h10, 32'h0, rd, flt, cyc);
    chk("ldw10_after_stb", rd, 32'h11AA_3344);

    access(0, 1, 2'b00, 0, 8'h20, 32'h0000_0080, rd, flt, cyc);
    access(0, 0, 2'b00, 1, 8'h20, 32'h0, rd, flt, cyc);
    chk("ldb_sext", rd, 32'hFFFF_FF80);
    access(0, 0, 2'b00, 0, 8'h20, 32'h0, rd, flt, cyc);
    chk("ldb_zext", rd, 32'h0000_0080);
    access(0, 1, 2'b01, 0, 8'h22, 32'h1234_8001, rd, flt, cyc);
    access(0, 0, 2'b01, 1, 8'h22, 32'h0, rd, flt, cyc);
    chk("ldh_sext", rd, 32'hFFFF_8001);

    access(0, 1, 2'b10, 0, 8'h30, 32'h0102_0304, rd, flt, cyc);
    access(0, 1, 2'b01, 0, 8'h31, 32'h0000_BEEF, rd, flt, cyc);
    chk("sth_mis_fault", {31'h0, flt}, 32'h1);
    chk("sth_mis_rdata", rd, 32'h0);
    access(0, 0, 2'b10, 0, 8'h30, 32'h0, rd, flt, cyc);
    chk("mem_unchanged", rd, 32'h0102_0304);
    access(0, 0, 2'b11, 1, 8'h34, 32'h0, rd, flt, cyc);
    chk("sz11_fault", {31'h0, flt}, 32'h1);
    chk("sz11_rdata", rd, 32'h0);

    // latency 4 with req held high across two full accesses
    req_s[1] = 1; we_s[1] = 1; size_s[1] = 2'b10; sgn_s[1] = 0;
    addr_s[1] = 8'h40; wdata_s[1] = 32'hDEAD_BEEF;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      nbusy += int'(busy_o[1]);
      ndone += int'(done_o[1]);
    end
    req_s[1] = 0;
    chk("hold_busy_cycles", 32'(nbusy), 32'd10);
    chk("hold_done_count", 32'(ndone), 32'd2);
    @(posedge clk); #1;
    access(1, 0, 2'b10, 0, 8'h40, 32'h0, rd, flt, cyc);
    chk("ld40", rd, 32'hDEAD_BEEF);
    chk("ld40_lat", 32'(cyc), 32'd4);

    // reset during WAIT abandons the store
    access(1, 1, 2'b10, 0, 8'h50, 32'h9988_7766, rd, flt, cyc);
    req_s[1] = 1; we_s[1] = 1; size_s[1] = 2'b00; addr_s[1] = 8'h50; wdata_s[1] = 32'h55;
    @(posedge clk); #1;
    req_s[1] = 0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", {31'h0, busy_o[1]}, 32'h0);
    chk("rstw_done", {31'h0, done_o[1]}, 32'h0);
    chk("rstw_fault", {31'h0, fault_o[1]}, 32'h0);
    chk("rstw_rdata", rdata_o[1], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 2'b10, 0, 8'h50, 32'h0, rd, flt, cyc);
    chk("rstw_mem", rd, 32'h9988_7766);

    for (int n = 0; n < 250; n++) begin
      for (int d = 0; d < 2; d++) begin
        access(d, 1'($urandom), 2'($urandom), 1'($urandom), AW'($urandom), $urandom,
               rd, flt, cyc);
        chk("rand_lat", 32'(cyc), 32'(lat_of(d)));
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
